// File: rtl/wts_adsr_pkg.sv
// Shared definitions for the time-multiplexed ADSR envelope engine.
package wts_adsr_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_ATTACK  = 3'd1;
    localparam logic [STATE_W-1:0] ST_DECAY   = 3'd2;
    localparam logic [STATE_W-1:0] ST_SUSTAIN = 3'd3;
    localparam logic [STATE_W-1:0] ST_RELEASE = 3'd4;

endpackage

// File: rtl/wts_adsr_envelope_generator_nch_step.sv
// Combinational single-channel ADSR step: applies key events or one rate step.
module wts_adsr_step
    import wts_adsr_pkg::*;
#(
    parameter int CNT_W   = 20,
    parameter int LEVEL_W = 7,
    parameter int RATE_W  = 8,
    parameter int SL_W    = 6
) (
    input  logic [STATE_W-1:0] state,
    input  logic [CNT_W-1:0]   cnt,
    input  logic [LEVEL_W-1:0] level,
    input  logic [RATE_W-1:0]  ar,
    input  logic [RATE_W-1:0]  dr,
    input  logic [RATE_W-1:0]  sr,
    input  logic [RATE_W-1:0]  rr,
    input  logic [SL_W-1:0]    sl,
    input  logic               ev_on,
    input  logic               ev_release,
    input  logic               ev_off,
    output logic [STATE_W-1:0] state_next,
    output logic [CNT_W-1:0]   cnt_next,
    output logic [LEVEL_W-1:0] level_next
);

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = {LEVEL_W{1'b1}};

    logic [RATE_W-1:0]  rate;
    logic [CNT_W:0]     sum;
    logic               carry;
    logic [LEVEL_W-1:0] target;
    logic [LEVEL_W-1:0] lvl_up;
    logic [LEVEL_W-1:0] lvl_dn;

    always_comb begin
        case (state)
            ST_ATTACK:  rate = ar;
            ST_DECAY:   rate = dr;
            ST_SUSTAIN: rate = sr;
            ST_RELEASE: rate = rr;
            default:    rate = '0;
        endcase
        sum    = {1'b0, cnt} + (CNT_W+1)'(rate);
        carry  = sum[CNT_W];
        target = LEVEL_W'(sl) << (LEVEL_W - SL_W);
        // Level saturates at both ends instead of wrapping.
        lvl_up = (carry && level != LEVEL_MAX) ? level + 1'b1 : level;
        lvl_dn = (carry && level != '0) ? level - 1'b1 : level;

        state_next = state;
        cnt_next   = cnt;
        level_next = level;

        if (ev_off) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            level_next = '0;
        end else if (ev_on) begin
            state_next = ST_ATTACK;
            cnt_next   = '0;
            level_next = '0;
        end else if (ev_release && state != ST_IDLE) begin
            state_next = ST_RELEASE;
        end else begin
            case (state)
                ST_ATTACK: begin
                    cnt_next   = sum[CNT_W-1:0];
                    level_next = lvl_up;
                    if (lvl_up == LEVEL_MAX) begin
                        state_next = ST_DECAY;
                        cnt_next   = '0;
                    end
                end
                ST_DECAY: begin
                    cnt_next   = sum[CNT_W-1:0];
                    level_next = lvl_dn;
                    if (lvl_dn <= target) begin
                        state_next = ST_SUSTAIN;
                        cnt_next   = '0;
                    end
                end
                ST_SUSTAIN, ST_RELEASE: begin
                    cnt_next   = sum[CNT_W-1:0];
                    level_next = lvl_dn;
                    if (lvl_dn == '0) state_next = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/wts_adsr_envelope_generator_nch.sv
// Time-multiplexed ADSR envelope engine: per-channel storage, latched key events, tagged output.
module wts_adsr_envelope_generator_nch
    import wts_adsr_pkg::*;
#(
    parameter int CH_NUM  = 5,
    parameter int ACT_W   = 3,
    parameter int CNT_W   = 20,
    parameter int LEVEL_W = 7,
    parameter int RATE_W  = 8,
    parameter int SL_W    = 6
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic [ACT_W-1:0]         active,
    input  logic [CH_NUM-1:0]        key_on,
    input  logic [CH_NUM-1:0]        key_release,
    input  logic [CH_NUM-1:0]        key_off,
    input  logic [CH_NUM*RATE_W-1:0] reg_ar,
    input  logic [CH_NUM*RATE_W-1:0] reg_dr,
    input  logic [CH_NUM*RATE_W-1:0] reg_sr,
    input  logic [CH_NUM*RATE_W-1:0] reg_rr,
    input  logic [CH_NUM*SL_W-1:0]   reg_sl,
    output logic [LEVEL_W-1:0]       envelope,
    output logic                     envelope_valid,
    output logic [ACT_W-1:0]         envelope_ch,
    output logic [CH_NUM-1:0]        ch_busy
);

    logic [STATE_W-1:0] st_q  [CH_NUM];
    logic [CNT_W-1:0]   cnt_q [CH_NUM];
    logic [LEVEL_W-1:0] lvl_q [CH_NUM];
    logic [CH_NUM-1:0]  pend_on, pend_rel, pend_off;

    logic [CH_NUM-1:0]  slot_sel;
    logic               slot_valid;
    logic [STATE_W-1:0] cur_st, nxt_st;
    logic [CNT_W-1:0]   cur_cnt, nxt_cnt;
    logic [LEVEL_W-1:0] cur_lvl, nxt_lvl;
    logic [RATE_W-1:0]  cur_ar, cur_dr, cur_sr, cur_rr;
    logic [SL_W-1:0]    cur_sl;
    logic               ev_on, ev_rel, ev_off;
    logic [CH_NUM-1:0]  busy_next;

    // Slot indices at or above CH_NUM match no channel and leave everything idle.
    always_comb begin
        slot_sel = '0;
        cur_st   = ST_IDLE;
        cur_cnt  = '0;
        cur_lvl  = '0;
        cur_ar   = '0;
        cur_dr   = '0;
        cur_sr   = '0;
        cur_rr   = '0;
        cur_sl   = '0;
        ev_on    = 1'b0;
        ev_rel   = 1'b0;
        ev_off   = 1'b0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (active == ACT_W'(k)) begin
                slot_sel[k] = 1'b1;
                cur_st      = st_q[k];
                cur_cnt     = cnt_q[k];
                cur_lvl     = lvl_q[k];
                cur_ar      = reg_ar[k*RATE_W +: RATE_W];
                cur_dr      = reg_dr[k*RATE_W +: RATE_W];
                cur_sr      = reg_sr[k*RATE_W +: RATE_W];
                cur_rr      = reg_rr[k*RATE_W +: RATE_W];
                cur_sl      = reg_sl[k*SL_W +: SL_W];
                ev_on       = key_on[k] | pend_on[k];
                ev_rel      = key_release[k] | pend_rel[k];
                ev_off      = key_off[k] | pend_off[k];
            end
        end
        slot_valid = |slot_sel;
    end

    wts_adsr_step #(
        .CNT_W   (CNT_W),
        .LEVEL_W (LEVEL_W),
        .RATE_W  (RATE_W),
        .SL_W    (SL_W)
    ) u_step (
        .state      (cur_st),
        .cnt        (cur_cnt),
        .level      (cur_lvl),
        .ar         (cur_ar),
        .dr         (cur_dr),
        .sr         (cur_sr),
        .rr         (cur_rr),
        .sl         (cur_sl),
        .ev_on      (ev_on),
        .ev_release (ev_rel),
        .ev_off     (ev_off),
        .state_next (nxt_st),
        .cnt_next   (nxt_cnt),
        .level_next (nxt_lvl)
    );

    always_comb begin
        busy_next = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            busy_next[k] = slot_sel[k] ? (nxt_st != ST_IDLE) : (st_q[k] != ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int k = 0; k < CH_NUM; k++) begin
                st_q[k]  <= ST_IDLE;
                cnt_q[k] <= '0;
                lvl_q[k] <= '0;
            end
            pend_on        <= '0;
            pend_rel       <= '0;
            pend_off       <= '0;
            envelope       <= '0;
            envelope_valid <= 1'b0;
            envelope_ch    <= '0;
            ch_busy        <= '0;
        end else begin
            for (int k = 0; k < CH_NUM; k++) begin
                if (slot_sel[k]) begin
                    st_q[k]  <= nxt_st;
                    cnt_q[k] <= nxt_cnt;
                    lvl_q[k] <= nxt_lvl;
                end
            end
            // A pulse landing on its own slot is consumed there and never latched.
            pend_on        <= (pend_on  | key_on)      & ~slot_sel;
            pend_rel       <= (pend_rel | key_release) & ~slot_sel;
            pend_off       <= (pend_off | key_off)     & ~slot_sel;
            envelope_valid <= slot_valid;
            ch_busy        <= busy_next;
            if (slot_valid) begin
                envelope    <= nxt_lvl;
                envelope_ch <= active;
            end
        end
    end

endmodule

// File: tb/tb_wts_adsr_envelope_generator_nch.sv
// Directed bench for the ADSR engine with a behavioural model feeding an expected-output queue.
module tb_wts_adsr_envelope_generator_nch;

    localparam int CH = 5;

    logic        clk = 1'b0;
    logic        nreset;
    logic [2:0]  active;
    logic [4:0]  key_on, key_release, key_off;
    logic [39:0] reg_ar, reg_dr, reg_sr, reg_rr;
    logic [29:0] reg_sl;
    logic [6:0]  envelope;
    logic        envelope_valid;
    logic [2:0]  envelope_ch;
    logic [4:0]  ch_busy;

    int ar_v[CH], dr_v[CH], sr_v[CH], rr_v[CH], sl_v[CH];

    // Model state
    int m_st[CH], m_cnt[CH], m_lvl[CH];
    bit m_pon[CH], m_prel[CH], m_poff[CH];
    int e_env, e_ch;

    logic [15:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int peak;

    wts_adsr_envelope_generator_nch #(
        .CH_NUM(5), .ACT_W(3), .CNT_W(8), .LEVEL_W(7), .RATE_W(8), .SL_W(6)
    ) dut (
        .clk            (clk),
        .nreset         (nreset),
        .active         (active),
        .key_on         (key_on),
        .key_release    (key_release),
        .key_off        (key_off),
        .reg_ar         (reg_ar),
        .reg_dr         (reg_dr),
        .reg_sr         (reg_sr),
        .reg_rr         (reg_rr),
        .reg_sl         (reg_sl),
        .envelope       (envelope),
        .envelope_valid (envelope_valid),
        .envelope_ch    (envelope_ch),
        .ch_busy        (ch_busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        reg_ar = '0;
        reg_dr = '0;
        reg_sr = '0;
        reg_rr = '0;
        reg_sl = '0;
        for (int k = 0; k < CH; k++) begin
            reg_ar[k*8 +: 8] = 8'(ar_v[k]);
            reg_dr[k*8 +: 8] = 8'(dr_v[k]);
            reg_sr[k*8 +: 8] = 8'(sr_v[k]);
            reg_rr[k*8 +: 8] = 8'(rr_v[k]);
            reg_sl[k*6 +: 6] = 6'(sl_v[k]);
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            m_st[k] = 0; m_cnt[k] = 0; m_lvl[k] = 0;
            m_pon[k] = 0; m_prel[k] = 0; m_poff[k] = 0;
        end
        e_env = 0;
        e_ch  = 0;
    endtask

    // Rate step: the counter overflows past 255 to produce one level move.
    task automatic model_slot(input int a, input logic [4:0] on, input logic [4:0] rel, input logic [4:0] off);
        int s;
        bit eon, erel, eoff, valid;
        logic [4:0] busy;
        for (int k = 0; k < CH; k++) begin
            if (on[k])  m_pon[k]  = 1;
            if (rel[k]) m_prel[k] = 1;
            if (off[k]) m_poff[k] = 1;
        end
        valid = (a < CH);
        if (valid) begin
            eon = m_pon[a]; erel = m_prel[a]; eoff = m_poff[a];
            m_pon[a] = 0; m_prel[a] = 0; m_poff[a] = 0;
            if (eoff) begin
                m_st[a] = 0; m_cnt[a] = 0; m_lvl[a] = 0;
            end else if (eon) begin
                m_st[a] = 1; m_cnt[a] = 0; m_lvl[a] = 0;
            end else if (erel && m_st[a] != 0) begin
                m_st[a] = 4;
            end else if (m_st[a] != 0) begin
                case (m_st[a])
                    1: s = m_cnt[a] + ar_v[a];
                    2: s = m_cnt[a] + dr_v[a];
                    3: s = m_cnt[a] + sr_v[a];
                    default: s = m_cnt[a] + rr_v[a];
                endcase
                m_cnt[a] = s % 256;
                if (s >= 256) begin
                    if (m_st[a] == 1) begin
                        if (m_lvl[a] < 127) m_lvl[a]++;
                    end else if (m_lvl[a] > 0) begin
                        m_lvl[a]--;
                    end
                end
                if (m_st[a] == 1 && m_lvl[a] == 127) begin
                    m_st[a] = 2; m_cnt[a] = 0;
                end else if (m_st[a] == 2 && m_lvl[a] <= sl_v[a] * 2) begin
                    m_st[a] = 3; m_cnt[a] = 0;
                end else if ((m_st[a] == 3 || m_st[a] == 4) && m_lvl[a] == 0) begin
                    m_st[a] = 0;
                end
            end
            e_env = m_lvl[a];
            e_ch  = a;
        end
        for (int k = 0; k < CH; k++) busy[k] = (m_st[k] != 0);
        exp_q.push_back({valid, 3'(e_ch), 7'(e_env), busy});
    endtask

    task automatic slot(input int a, input logic [4:0] on, input logic [4:0] rel, input logic [4:0] off);
        logic [15:0] e;
        @(negedge clk);
        active      = 3'(a);
        key_on      = on;
        key_release = rel;
        key_off     = off;
        model_slot(a, on, rel, off);
        @(posedge clk);
        #1;
        key_on      = '0;
        key_release = '0;
        key_off     = '0;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL queue_empty observed 0 expected 1");
        end else begin
            e = exp_q.pop_front();
            chk("valid", 16'(envelope_valid), 16'(e[15]));
            chk("env_ch", 16'(envelope_ch), 16'(e[14:12]));
            chk("envelope", 16'(envelope), 16'(e[11:5]));
            chk("ch_busy", 16'(ch_busy), 16'(e[4:0]));
        end
    endtask

    initial begin
        nreset = 1'b0;
        active = '0;
        key_on = '0; key_release = '0; key_off = '0;
        for (int k = 0; k < CH; k++) begin
            ar_v[k] = 0; dr_v[k] = 0; sr_v[k] = 0; rr_v[k] = 0; sl_v[k] = 0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_envelope", 16'(envelope), 16'd0);
        chk("rst_valid", 16'(envelope_valid), 16'd0);
        chk("rst_ch", 16'(envelope_ch), 16'd0);
        chk("rst_busy", 16'(ch_busy), 16'd0);
        @(negedge clk);
        nreset = 1'b1;

        // Idle sweep including the out-of-range slot
        for (int a = 0; a <= 5; a++) slot(a, 5'b0, 5'b0, 5'b0);

        // Key-on latched on slot 0, consumed on slot 2
        ar_v[2] = 128;
        slot(0, 5'b00100, 5'b0, 5'b0);
        for (int r = 0; r < 4; r++)
            for (int a = 0; a < 5; a++) slot(a, 5'b0, 5'b0, 5'b0);

        // Full attack, decay to sustain at 64, hold with sr = 0
        ar_v[1] = 255; dr_v[1] = 255; sl_v[1] = 32; sr_v[1] = 0;
        slot(1, 5'b00010, 5'b0, 5'b0);
        peak = 0;
        for (int i = 0; i < 220; i++) begin
            slot(1, 5'b0, 5'b0, 5'b0);
            if (int'(envelope) > peak) peak = int'(envelope);
        end
        chk("attack_peak", 16'(peak), 16'd127);
        chk("sustain_hold", 16'(envelope), 16'd64);
        chk("sustain_busy", 16'(ch_busy[1]), 16'd1);

        // Release down to idle
        rr_v[1] = 255;
        slot(1, 5'b0, 5'b00010, 5'b0);
        for (int i = 0; i < 70; i++) slot(1, 5'b0, 5'b0, 5'b0);
        chk("release_level", 16'(envelope), 16'd0);
        chk("release_busy", 16'(ch_busy[1]), 16'd0);

        // Off beats on, both coincident and both latched
        ar_v[3] = 200;
        slot(0, 5'b01000, 5'b0, 5'b01000);
        slot(3, 5'b0, 5'b0, 5'b0);
        chk("off_wins_busy", 16'(ch_busy[3]), 16'd0);
        slot(0, 5'b0, 5'b0, 5'b01000);
        slot(0, 5'b01000, 5'b0, 5'b0);
        slot(3, 5'b0, 5'b0, 5'b0);
        chk("off_wins_latched", 16'(envelope), 16'd0);

        // Key-on coincident with its own slot starts attack without leaving a pending flag
        ar_v[4] = 255;
        slot(4, 5'b10000, 5'b0, 5'b0);
        chk("on_direct_busy", 16'(ch_busy[4]), 16'd1);
        for (int i = 0; i < 3; i++) slot(4, 5'b0, 5'b0, 5'b0);
        chk("on_direct_level", 16'(envelope), 16'd2);

        // Asynchronous reset mid-attack
        ar_v[0] = 255;
        slot(0, 5'b00001, 5'b0, 5'b0);
        for (int i = 0; i < 200 && m_lvl[0] != 50; i++) slot(0, 5'b0, 5'b0, 5'b0);
        chk("pre_reset_level", 16'(envelope), 16'd50);
        #2;
        nreset = 1'b0;
        #1;
        chk("areset_envelope", 16'(envelope), 16'd0);
        chk("areset_valid", 16'(envelope_valid), 16'd0);
        chk("areset_ch", 16'(envelope_ch), 16'd0);
        chk("areset_busy", 16'(ch_busy), 16'd0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i < 3; i++) slot(0, 5'b0, 5'b0, 5'b0);

        chk("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wts_adsr_envelope_generator_nch.md
Name: wts_adsr_envelope_generator_nch

Overview:
Parametrised, time-multiplexed ADSR envelope engine. It serves CH_NUM wave-table channels with one shared step datapath, selecting one channel per cycle via the slot index `active`. Compared with the fixed 5-channel generation it adds three things: per-channel latching of key events between slots, a registered and tagged envelope output, and a per-channel busy status. It sits between the register file (key events and rates) and the wave mixer (envelope scaling).

Parameters:
CH_NUM, 5, number of channels (2..16)
ACT_W, 3, width of `active`; must satisfy 2^ACT_W > CH_NUM
CNT_W, 20, phase accumulator width per channel
LEVEL_W, 7, envelope level width
RATE_W, 8, width of each AR/DR/SR/RR rate field
SL_W, 6, sustain level width; SL_W <= LEVEL_W

Ports:
clk  in  1  system clock, all logic on rising edge
nreset  in  1  asynchronous, active-low reset
active  in  ACT_W  slot index; values 0..CH_NUM-1 service that channel, values >= CH_NUM are no-op
key_on  in  CH_NUM  per-channel key-on pulse
key_release  in  CH_NUM  per-channel key-release pulse
key_off  in  CH_NUM  per-channel immediate-off pulse
reg_ar  in  CH_NUM*RATE_W  packed attack rates; channel k at [k*RATE_W +: RATE_W]
reg_dr  in  CH_NUM*RATE_W  packed decay rates
reg_sr  in  CH_NUM*RATE_W  packed sustain rates
reg_rr  in  CH_NUM*RATE_W  packed release rates
reg_sl  in  CH_NUM*SL_W  packed sustain levels
envelope  out  LEVEL_W  registered level of the channel serviced in the previous cycle
envelope_valid  out  1  high for one cycle after a valid slot
envelope_ch  out  ACT_W  channel tag for `envelope`
ch_busy  out  CH_NUM  bit k high when channel k state is not IDLE

Behaviour:
- Reset values: every state = IDLE, every counter = 0, every level = 0, all pending flags = 0. Outputs reset to envelope = 0, envelope_valid = 0, envelope_ch = 0, ch_busy = 0. Reset asserted mid-operation clears everything on the next nreset low, with no completion of the in-flight slot.
- States (encodings defined in the package): IDLE = 0, ATTACK = 1, DECAY = 2, SUSTAIN = 3, RELEASE = 4.
- Pending latch:
  - A pulse on key_*[k] sets pend_*[k].
  - The flag is consumed (cleared) when slot k is serviced.
  - A pulse arriving in the same cycle as slot k is serviced is consumed directly and is not left pending.
  - Effective event for channel k = pulse OR pending flag.
- Event priority, evaluated on the serviced channel only:
  - off: level = 0, counter = 0, state = IDLE.
  - else on: level = 0, counter = 0, state = ATTACK.
  - else release: if state != IDLE, state = RELEASE with level and counter kept.
  - An applied event replaces the normal step for that slot.
- Step, when no event applies:
  - rate = AR/DR/SR/RR according to state.
  - {carry, counter} = counter + rate, computed at CNT_W+1 bits.
  - On carry, level moves by 1.
  - rate = 0 means the level never moves.
- Level and state rules:
  - ATTACK: level += 1 on carry. On reaching 2^LEVEL_W-1, state = DECAY and counter = 0.
  - DECAY: level -= 1 on carry. When level <= sl << (LEVEL_W-SL_W), state = SUSTAIN and counter = 0. If the target is >= max level, the move to SUSTAIN is immediate.
  - SUSTAIN: level -= 1 on carry. Level 0 -> IDLE.
  - RELEASE: level -= 1 on carry. Level 0 -> IDLE.
  - IDLE: hold. Level never wraps past 0 or past the maximum.
- Output timing:
  - Slot serviced in cycle n -> envelope = post-update level, envelope_valid = 1, envelope_ch = active in cycle n+1. Latency 1.
  - active >= CH_NUM: no state change, envelope_valid = 0, envelope and envelope_ch hold.
  - ch_busy is registered from the stored states and reflects updates one cycle after the slot.
- Channels not serviced hold all storage. The same channel in consecutive cycles is legal.

Decomposition:
- Package wts_adsr_pkg holds the state encodings and the state width (3).
- Sub-module wts_adsr_step: purely combinational single-channel step. Inputs are state, counter, level, rates, sl and effective events; outputs are next state, counter and level.
- The top module holds per-channel storage arrays, pending flags, slot muxing and the output registers.

Test Plan:
All scenarios use CNT_W=8 and CH_NUM=5.
1. Reset then idle slots 0..5 -> envelope_valid pulses for slots 0..4 only, envelope = 0, ch_busy = 0.
2. key_on[2] while active = 0, ar[2] = 128, slots cycled 0..4 -> pend held until slot 2; level2 +1 every 2nd ch2 service; ch_busy[2] = 1 one cycle after the first ch2 slot.
3. Ch1 with ar = 255, dr = 255, sl = 32 -> level climbs to 127, DECAY, falls to 64, then SUSTAIN; with sr = 0 it holds at 64 indefinitely.
4. Ch1 in SUSTAIN at 64, key_release, rr = 255 -> RELEASE, level falls to 0 at one step per ch1 slot, then IDLE and ch_busy[1] = 0.
5. key_on[3] and key_off[3] in the same cycle, or key_off latched then key_on -> off wins: level3 = 0, IDLE. Also: key_on[4] coincident with slot 4 -> pend_on[4] stays 0 and ATTACK starts that slot.
6. Drive nreset low while ch0 is in ATTACK at level 50 -> all outputs 0 immediately; after release, ch0 stays IDLE until a new key_on.
